// File: rtl/mod_sinesource_mc.sv
// mod_sinesource_mc: time-multiplexed multi-channel sine oscillator with a valid/ready sample stream.
// Optional feature macro: SINESOURCE_QUADRATURE_EN adds o_cosine (quarter-period shifted output).

module mod_sine16 (
  input  logic signed [15:0] i_angle,
  output logic signed [15:0] o_sine
);
  // Bhaskara I rational approximation per half period; 0..32767 spans one full period.
  logic [14:0]        a15;
  logic [13:0]        a;
  logic [26:0]        t;
  logic [44:0]        num;
  logic [44:0]        den;
  logic signed [15:0] mag;

  // NOTE: blocking assignments are correct here: these are combinational temporaries
  // evaluated in order, whereas every clocked register uses non-blocking assignments.
  always_comb begin
    a15    = 15'(i_angle);
    a      = a15[13:0];
    t      = 27'(a) * (27'd16384 - 27'(a));
    num    = 45'(t) * 45'd131068;
    den    = 45'd335544320 - 45'(t);
    mag    = 16'(num / den);
    o_sine = a15[14] ? -mag : mag;
  end
endmodule

module mod_sinesource_mc #(
  parameter  int NCH     = 4,
  parameter  int PHASE_W = 32,
  parameter  int GAIN_W  = 20,
  parameter  int OUT_W   = 32,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic                    i_cfg_we,
  input  logic [1:0]              i_cfg_sel,
  input  logic [CW-1:0]           i_cfg_addr,
  input  logic [31:0]             i_cfg_data,
  output logic signed [OUT_W-1:0] o_sample,
`ifdef SINESOURCE_QUADRATURE_EN
  output logic signed [OUT_W-1:0] o_cosine,
`endif
  output logic [CW-1:0]           o_chan,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_overrun,
  input  logic                    i_clr_overrun
);
  localparam int            PW   = GAIN_W + 17;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t             state;
  logic [CW-1:0]      ch;
  logic [PHASE_W-1:0] phase [NCH];
  logic [PHASE_W-1:0] incr  [NCH];
  logic [GAIN_W-1:0]  gain  [NCH];

  logic [14:0]          a15;
  logic signed [15:0]   sin_raw;
  logic signed [PW-1:0] sin_prod;
  logic signed [PW-1:0] sin_scaled;
  logic                 hs;
  logic                 cfg_hit;

  assign a15 = phase[ch][PHASE_W-1 -: 15];

  mod_sine16 u_sin (.i_angle({1'b0, a15}), .o_sine(sin_raw));

  assign sin_prod   = PW'(sin_raw) * PW'($signed({1'b0, gain[ch]}));
  assign sin_scaled = sin_prod >>> 13;

`ifdef SINESOURCE_QUADRATURE_EN
  logic [14:0]          a15_q;
  logic signed [15:0]   cos_raw;
  logic signed [PW-1:0] cos_prod;
  logic signed [PW-1:0] cos_scaled;

  assign a15_q = a15 + 15'd8192;

  mod_sine16 u_cos (.i_angle({1'b0, a15_q}), .o_sine(cos_raw));

  assign cos_prod   = PW'(cos_raw) * PW'($signed({1'b0, gain[ch]}));
  assign cos_scaled = cos_prod >>> 13;
`endif

  assign hs      = (state == EMIT) && o_valid && i_ready;
  assign cfg_hit = i_cfg_we && (int'(i_cfg_addr) < NCH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      o_sample  <= '0;
`ifdef SINESOURCE_QUADRATURE_EN
      o_cosine  <= '0;
`endif
      o_chan    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      // NOTE: the channel register file is reset element by element because every
      // channel must restart from a defined phase, increment and gain.
      for (int i = 0; i < NCH; i++) begin
        phase[i] <= '0;
        incr[i]  <= '0;
        gain[i]  <= GAIN_W'(17'h10000);
      end
    end else begin
      // A tick seen outside IDLE is dropped; setting takes priority over clearing.
      if (i_tick && (state != IDLE)) o_overrun <= 1'b1;
      else if (i_clr_overrun)        o_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (i_tick) begin
            ch     <= '0;
            o_busy <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          o_sample <= OUT_W'(sin_scaled);
`ifdef SINESOURCE_QUADRATURE_EN
          o_cosine <= OUT_W'(cos_scaled);
`endif
          o_chan   <= ch;
          o_valid  <= 1'b1;
          state    <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            phase[ch] <= phase[ch] + incr[ch];
            o_valid   <= 1'b0;
            if (ch == LAST) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              ch    <= ch + CW'(1);
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the accumulation so a same-cycle phase load overrides it.
      if (cfg_hit) begin
        case (i_cfg_sel)
          2'd0:    incr[i_cfg_addr]  <= PHASE_W'(i_cfg_data);
          2'd1:    gain[i_cfg_addr]  <= GAIN_W'(i_cfg_data);
          2'd2:    phase[i_cfg_addr] <= PHASE_W'(i_cfg_data);
          default: ;
        endcase
      end
    end
  end
endmodule
